// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the fetch PC, issues one imem request at a time and
// buffers returned words with their PCs for decode.
module ifu_fetch #(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [PC_W-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [PC_W-1:0] inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] fetch_pc_nxt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [PC_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [PC_W-1:0] inst_mem [FIFO_DEPTH];
  logic            has_room;
  logic            req_fire;
  logic            push;
  logic            pop;

  // Room is checked at request time so the later push cannot overflow.
  assign has_room       = count < CW'(FIFO_DEPTH);
  assign imem_req_valid = !rst && (state == S_REQ) &&
                          has_room && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign inst_valid = count != '0;
  assign pop        = inst_valid & inst_ready;
  assign inst       = inst_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    unique case (state)
      S_REQ: begin
        if (req_fire) begin
          state_nxt    = S_WAIT;
          fetch_pc_nxt = fetch_pc + PC_W'(4);
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
          push      = !redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    if (redirect_valid) fetch_pc_nxt = redirect_pc & ~PC_W'(3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The pushed word belongs to the request issued one step before fetch_pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc - PC_W'(4);
      inst_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios plus random traffic checked every
// cycle against a queue-based model of the fetch stream.
module tb_ifu_fetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu_fetch #(
    .PC_W(32),
    .RESET_PC(RPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // Model: stream of delivered words, one owed response, and whether
  // that response must be thrown away because of a redirect.
  ent_t        q[$];
  bit          pending;
  bit          stale;
  logic [31:0] m_pc;
  logic [31:0] pend_pc;
  int          mem_cnt;
  int          mem_delay;
  int          n_pass;
  int          n_total;

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endfunction

  function automatic void model_reset();
    q.delete();
    pending = 0;
    stale   = 0;
    m_pc    = RPC;
    pend_pc = '0;
    mem_cnt = 0;
  endfunction

  task automatic compare();
    logic erv;
    erv = !pending && (q.size() < DEPTH) && !redirect_valid;
    chk("req_valid", imem_req_valid, erv);
    if (erv) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("inst", inst, q[0].inst);
      chk("inst_pc", inst_pc, q[0].pc);
    end
  endtask

  function automatic void update();
    int n0;
    n0 = q.size();
    if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc & ~32'h3;
      if (pending) begin
        if (imem_rsp_valid) begin
          pending = 0;
          stale   = 0;
        end else begin
          stale = 1;
        end
      end
    end else begin
      if (n0 != 0 && inst_ready) void'(q.pop_front());
      if (pending && imem_rsp_valid) begin
        if (!stale) q.push_back('{pend_pc, imem_rsp_data});
        pending = 0;
        stale   = 0;
      end else if (!pending && n0 < DEPTH && imem_req_ready) begin
        pending = 1;
        pend_pc = m_pc;
        m_pc    = m_pc + 32'd4;
        mem_cnt = mem_delay;
      end
    end
  endfunction

  // One clock: memory answers owed requests, outputs are compared
  // before the edge, the model advances on the edge.
  task automatic step();
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
      end
    end
    #1;
    compare();
    @(posedge clk);
    update();
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_addr", imem_req_addr, RPC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    mem_delay = 1;
    rst = 1'b1;
    model_reset();

    // Back-to-back fetch from reset
    do_reset();
    imem_req_ready = 1; inst_ready = 1;
    #1;
    chk("t1_rv0", imem_req_valid, 1'b1);
    chk("t1_addr0", imem_req_addr, 32'h8000_0000);
    step();
    step();
    #1;
    chk("t1_iv", inst_valid, 1'b1);
    chk("t1_pc0", inst_pc, 32'h8000_0000);
    chk("t1_addr1", imem_req_addr, 32'h8000_0004);
    step();
    step();
    #1;
    chk("t1_pc1", inst_pc, 32'h8000_0004);
    chk("t1_addr2", imem_req_addr, 32'h8000_0008);
    step();

    // Decode stalled until the buffer fills
    do_reset();
    imem_req_ready = 1; inst_ready = 0;
    repeat (8) step();
    #1;
    chk("t2_rv_full", imem_req_valid, 1'b0);
    chk("t2_head", inst_pc, 32'h8000_0000);
    inst_ready = 1;
    step();
    #1;
    chk("t2_head2", inst_pc, 32'h8000_0004);
    chk("t2_rv", imem_req_valid, 1'b1);
    chk("t2_addr", imem_req_addr, 32'h8000_0008);
    step();
    step();

    // Redirect while waiting; late response dropped
    do_reset();
    mem_delay = 3; imem_req_ready = 1; inst_ready = 1;
    step();
    redirect_valid = 1; redirect_pc = 32'h8000_0103;
    step();
    step();
    mem_delay = 1;
    step();
    #1;
    chk("t3_addr", imem_req_addr, 32'h8000_0100);
    chk("t3_iv0", inst_valid, 1'b0);
    step();
    step();
    #1;
    chk("t3_pc", inst_pc, 32'h8000_0100);
    step();

    // Redirect colliding with response and pop
    do_reset();
    imem_req_ready = 1; inst_ready = 0;
    repeat (3) step();
    #1;
    chk("t4_iv", inst_valid, 1'b1);
    redirect_valid = 1; redirect_pc = 32'h0000_1234; inst_ready = 1;
    step();
    #1;
    chk("t4_iv0", inst_valid, 1'b0);
    chk("t4_rv", imem_req_valid, 1'b1);
    chk("t4_addr", imem_req_addr, 32'h0000_1234);
    step();
    step();

    // Memory back-pressure holds the request
    do_reset();
    imem_req_ready = 0; inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_rv_hold", imem_req_valid, 1'b1);
      chk("t5_addr_hold", imem_req_addr, 32'h8000_0000);
      step();
    end
    imem_req_ready = 1;
    step();
    step();
    #1;
    chk("t5_addr_next", imem_req_addr, 32'h8000_0004);
    chk("t5_pc", inst_pc, 32'h8000_0000);
    step();

    // Reset mid-transaction, then a stray response
    do_reset();
    imem_req_ready = 1; inst_ready = 0;
    repeat (3) step();
    rst = 1;
    #1;
    chk("t6_rv", imem_req_valid, 1'b0);
    chk("t6_iv", inst_valid, 1'b0);
    chk("t6_pc", inst_pc, 32'h0);
    chk("t6_addr", imem_req_addr, RPC);
    @(negedge clk);
    rst = 0;
    model_reset();
    imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    #1;
    chk("t6_iv_stray", inst_valid, 1'b0);
    chk("t6_addr_first", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1; inst_ready = 1;
    repeat (6) step();

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      inst_ready     = ($urandom % 3) != 0;
      mem_delay      = 1 + int'($urandom % 3);
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = (($urandom % 4) == 0) ?
                       (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
